// File: rtl/ddr3_app_responder.sv
// ddr3_app_responder: stand-in for the DDR3 controller user (app_*) interface.
// Queues commands and write data, executes them in order against a small
// backing memory, returns read data after a fixed latency, and emulates
// calibration delay and periodic refresh back-pressure.
// The first refresh window opens one full REFRESH_PERIOD after calibration
// completes, so traffic can start immediately once init_calib_complete rises.
module ddr3_app_responder #(
  parameter int ADDR_WIDTH     = 29,
  parameter int DATA_WIDTH     = 128,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int READ_LATENCY   = 8,
  parameter int CMD_FIFO_DEPTH = 4,
  parameter int WDF_FIFO_DEPTH = 4,
  parameter int CALIB_CYCLES   = 16,
  parameter int REFRESH_PERIOD = 64,
  parameter int REFRESH_CYCLES = 4,
  parameter int WDF_MASK_POL   = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     app_addr,
  input  logic [2:0]                app_cmd,
  input  logic                      app_en,
  output logic                      app_rdy,
  input  logic [DATA_WIDTH-1:0]     app_wdf_data,
  input  logic                      app_wdf_wren,
  input  logic [DATA_WIDTH/8-1:0]   app_wdf_mask,
  input  logic                      app_wdf_end,
  output logic                      app_wdf_rdy,
  output logic [DATA_WIDTH-1:0]     app_rd_data,
  output logic                      app_rd_data_valid,
  output logic                      app_rd_data_end,
  output logic                      init_calib_complete,
  output logic                      cmd_error
);

  localparam int MASK_W    = DATA_WIDTH / 8;
  localparam int MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int CPW       = (CMD_FIFO_DEPTH > 1) ? $clog2(CMD_FIFO_DEPTH) : 1;
  localparam int WPW       = (WDF_FIFO_DEPTH > 1) ? $clog2(WDF_FIFO_DEPTH) : 1;
  localparam int CALW      = $clog2(CALIB_CYCLES + 1);
  localparam int REFW      = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam bit REF_EN    = (REFRESH_PERIOD != 0);
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // storage (not reset; memory contents survive reset, FIFOs are emptied via pointers)
  logic [2:0]                cmd_fifo_cmd  [CMD_FIFO_DEPTH];
  logic [MEM_DEPTH_LOG2-1:0] cmd_fifo_idx  [CMD_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]     wdf_fifo_data [WDF_FIFO_DEPTH];
  logic [MASK_W-1:0]         wdf_fifo_be   [WDF_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]     mem           [MEM_DEPTH];

  logic [CALW-1:0] calib_cnt_q, calib_cnt_d;
  logic            calib_q, calib_d;
  logic [REFW-1:0] ref_cnt_q, ref_cnt_d;
  logic            ref_seen_q, ref_seen_d;
  logic [CPW-1:0]  cmd_wr_ptr_q, cmd_wr_ptr_d, cmd_rd_ptr_q, cmd_rd_ptr_d;
  logic [CPW:0]    cmd_cnt_q, cmd_cnt_d;
  logic [WPW-1:0]  wdf_wr_ptr_q, wdf_wr_ptr_d, wdf_rd_ptr_q, wdf_rd_ptr_d;
  logic [WPW:0]    wdf_cnt_q, wdf_cnt_d;
  logic            app_rdy_q, app_rdy_d;
  logic            app_wdf_rdy_q, app_wdf_rdy_d;
  logic            cmd_error_q, cmd_error_d;
  logic [READ_LATENCY-1:0]                 vld_pipe_q, vld_pipe_d;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] data_pipe_q, data_pipe_d;

  logic                      cmd_push, cmd_pop, wdf_push, do_write, do_read;
  logic                      refresh_now, refresh_nxt;
  logic [2:0]                head_cmd;
  logic [MEM_DEPTH_LOG2-1:0] head_idx;
  logic [DATA_WIDTH-1:0]     rd_word, wdf_head_data;
  logic [MASK_W-1:0]         wdf_head_be, wdf_be_in;
  logic                      unused_inputs;

  // low address bits, aliasing upper bits and the beat-end marker carry no state here
  assign unused_inputs = ^{app_addr, app_wdf_end};

  assign head_cmd      = cmd_fifo_cmd[cmd_rd_ptr_q];
  assign head_idx      = cmd_fifo_idx[cmd_rd_ptr_q];
  assign wdf_head_data = wdf_fifo_data[wdf_rd_ptr_q];
  assign wdf_head_be   = wdf_fifo_be[wdf_rd_ptr_q];
  assign rd_word       = mem[head_idx];
  assign wdf_be_in     = (WDF_MASK_POL != 0) ? app_wdf_mask : ~app_wdf_mask;

  // handshakes and in-order execution decision
  assign cmd_push    = app_en & app_rdy_q;
  assign wdf_push    = app_wdf_wren & app_wdf_rdy_q;
  assign refresh_now = REF_EN && ref_seen_q && (32'(ref_cnt_q) < REFRESH_CYCLES);
  assign cmd_pop     = calib_q & ~refresh_now & (cmd_cnt_q != '0) &
                       ((head_cmd != CMD_WRITE) | (wdf_cnt_q != '0));
  assign do_write    = cmd_pop & (head_cmd == CMD_WRITE);
  assign do_read     = cmd_pop & (head_cmd == CMD_READ);

  // next-state for counters, FIFO pointers, ready flags and read pipeline
  always_comb begin
    calib_cnt_d = calib_q ? calib_cnt_q : calib_cnt_q + 1'b1;
    calib_d     = calib_q | (32'(calib_cnt_q) == CALIB_CYCLES - 1);

    ref_cnt_d  = ref_cnt_q;
    ref_seen_d = ref_seen_q;
    if (REF_EN && calib_q) begin
      if (32'(ref_cnt_q) == REFRESH_PERIOD - 1) begin
        ref_cnt_d  = '0;
        ref_seen_d = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q + 1'b1;
      end
    end
    refresh_nxt = REF_EN && ref_seen_d && (32'(ref_cnt_d) < REFRESH_CYCLES);

    cmd_wr_ptr_d = cmd_wr_ptr_q;
    if (cmd_push) cmd_wr_ptr_d = (cmd_wr_ptr_q == CPW'(CMD_FIFO_DEPTH - 1)) ? '0 : cmd_wr_ptr_q + 1'b1;
    cmd_rd_ptr_d = cmd_rd_ptr_q;
    if (cmd_pop)  cmd_rd_ptr_d = (cmd_rd_ptr_q == CPW'(CMD_FIFO_DEPTH - 1)) ? '0 : cmd_rd_ptr_q + 1'b1;
    cmd_cnt_d = cmd_cnt_q + (CPW+1)'(cmd_push) - (CPW+1)'(cmd_pop);

    wdf_wr_ptr_d = wdf_wr_ptr_q;
    if (wdf_push) wdf_wr_ptr_d = (wdf_wr_ptr_q == WPW'(WDF_FIFO_DEPTH - 1)) ? '0 : wdf_wr_ptr_q + 1'b1;
    wdf_rd_ptr_d = wdf_rd_ptr_q;
    if (do_write) wdf_rd_ptr_d = (wdf_rd_ptr_q == WPW'(WDF_FIFO_DEPTH - 1)) ? '0 : wdf_rd_ptr_q + 1'b1;
    wdf_cnt_d = wdf_cnt_q + (WPW+1)'(wdf_push) - (WPW+1)'(do_write);

    // ready flags look at next-cycle occupancy, so a freed entry shows one cycle later
    app_rdy_d     = calib_d & (cmd_cnt_d != (CPW+1)'(CMD_FIFO_DEPTH)) & ~refresh_nxt;
    app_wdf_rdy_d = calib_d & (wdf_cnt_d != (WPW+1)'(WDF_FIFO_DEPTH));

    cmd_error_d = cmd_error_q | (cmd_push & (app_cmd != CMD_WRITE) & (app_cmd != CMD_READ));

    vld_pipe_d     = '0;
    data_pipe_d    = '0;
    vld_pipe_d[0]  = do_read;
    data_pipe_d[0] = do_read ? rd_word : '0;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      data_pipe_d[i] = data_pipe_q[i-1];
    end
  end

  // control state, cleared on reset so queued and in-flight work is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calib_cnt_q   <= '0;
      calib_q       <= 1'b0;
      ref_cnt_q     <= '0;
      ref_seen_q    <= 1'b0;
      cmd_wr_ptr_q  <= '0;
      cmd_rd_ptr_q  <= '0;
      cmd_cnt_q     <= '0;
      wdf_wr_ptr_q  <= '0;
      wdf_rd_ptr_q  <= '0;
      wdf_cnt_q     <= '0;
      app_rdy_q     <= 1'b0;
      app_wdf_rdy_q <= 1'b0;
      cmd_error_q   <= 1'b0;
      vld_pipe_q    <= '0;
      data_pipe_q   <= '0;
    end else begin
      calib_cnt_q   <= calib_cnt_d;
      calib_q       <= calib_d;
      ref_cnt_q     <= ref_cnt_d;
      ref_seen_q    <= ref_seen_d;
      cmd_wr_ptr_q  <= cmd_wr_ptr_d;
      cmd_rd_ptr_q  <= cmd_rd_ptr_d;
      cmd_cnt_q     <= cmd_cnt_d;
      wdf_wr_ptr_q  <= wdf_wr_ptr_d;
      wdf_rd_ptr_q  <= wdf_rd_ptr_d;
      wdf_cnt_q     <= wdf_cnt_d;
      app_rdy_q     <= app_rdy_d;
      app_wdf_rdy_q <= app_wdf_rdy_d;
      cmd_error_q   <= cmd_error_d;
      vld_pipe_q    <= vld_pipe_d;
      data_pipe_q   <= data_pipe_d;
    end
  end

  // FIFO entry storage and byte-enabled memory update
  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cmd_fifo_cmd[cmd_wr_ptr_q] <= app_cmd;
      cmd_fifo_idx[cmd_wr_ptr_q] <= app_addr[3 +: MEM_DEPTH_LOG2];
    end
    if (wdf_push) begin
      wdf_fifo_data[wdf_wr_ptr_q] <= app_wdf_data;
      wdf_fifo_be[wdf_wr_ptr_q]   <= wdf_be_in;
    end
    if (do_write) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (wdf_head_be[b]) mem[head_idx][b*8 +: 8] <= wdf_head_data[b*8 +: 8];
      end
    end
  end

  assign app_rdy             = app_rdy_q;
  assign app_wdf_rdy         = app_wdf_rdy_q;
  assign app_rd_data         = data_pipe_q[READ_LATENCY-1];
  assign app_rd_data_valid   = vld_pipe_q[READ_LATENCY-1];
  assign app_rd_data_end     = vld_pipe_q[READ_LATENCY-1];
  assign init_calib_complete = calib_q;
  assign cmd_error           = cmd_error_q;

endmodule

// File: tb/tb_ddr3_app_responder.sv
// Bench for ddr3_app_responder: scenario tasks drive the app_* interface,
// reads push their expected data into a scoreboard and a negedge monitor
// pops and compares every returned beat.
`timescale 1ns/1ps
module tb_ddr3_app_responder;
  localparam int L = 8;
  localparam logic [2:0] WR = 3'b000, RD = 3'b001;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [28:0]   app_addr = '0;
  logic [2:0]    app_cmd = '0;
  logic          app_en = 1'b0, app_rdy;
  logic [127:0]  app_wdf_data = '0;
  logic          app_wdf_wren = 1'b0, app_wdf_end = 1'b0, app_wdf_rdy;
  logic [15:0]   app_wdf_mask = '0;
  logic [127:0]  app_rd_data;
  logic          app_rd_data_valid, app_rd_data_end, init_calib_complete, cmd_error;

  ddr3_app_responder dut (
    .clk(clk), .rst_n(rst_n), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_rdy(app_rdy), .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
    .app_wdf_mask(app_wdf_mask), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end), .init_calib_complete(init_calib_complete),
    .cmd_error(cmd_error));

  always #5 clk = ~clk;

  // cycles since reset release; cycle k is the interval after the k-th rising edge
  int cyc;
  always @(posedge clk) if (!rst_n) cyc <= 0; else cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;
  logic [127:0] exp_data[$];
  int           exp_due[$];
  logic [127:0] model[int];
  logic [127:0] mon_exp;
  int           mon_due;

  function automatic int idx_of(input logic [28:0] a);
    return int'(a[12:3]);
  endfunction

  // refresh windows: one full period after calibration (cycle 16), 4 cycles every 64
  function automatic bit in_refresh(input int c);
    return (c >= 16 + 64) && (((c - 16) % 64) < 4);
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && app_rd_data_valid) begin
      vectors++;
      if (exp_data.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rd_valid cyc=%0d got=%h expected no beat", cyc, app_rd_data);
      end else begin
        mon_exp = exp_data.pop_front();
        mon_due = exp_due.pop_front();
        if (app_rd_data !== mon_exp) begin
          miscompares++;
          $display("FAIL rd_data cyc=%0d got=%h expected=%h", cyc, app_rd_data, mon_exp);
        end
        if (mon_due >= 0) begin
          vectors++;
          if (cyc != mon_due) begin
            miscompares++;
            $display("FAIL rd_latency got_cyc=%0d expected_cyc=%0d", cyc, mon_due);
          end
        end
      end
      vectors++;
      if (app_rd_data_end !== 1'b1) begin
        miscompares++;
        $display("FAIL rd_data_end got=%b expected=1", app_rd_data_end);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue_cmd(input logic [2:0] cmd, input logic [28:0] addr, output int acc);
    bit got = 0;
    acc = -1;
    app_en = 1'b1; app_cmd = cmd; app_addr = addr;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (app_rdy) begin got = 1; acc = cyc; end
      tick();
    end
    app_en = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL cmd_accept_timeout addr=%h got_rdy=%b expected 1", addr, app_rdy);
    end
  endtask

  task automatic issue_wdf(input logic [127:0] data, input logic [15:0] mask, output int acc);
    bit got = 0;
    acc = -1;
    app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = data; app_wdf_mask = mask;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (app_wdf_rdy) begin got = 1; acc = cyc; end
      tick();
    end
    app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL wdf_accept_timeout got_rdy=%b expected 1", app_wdf_rdy);
    end
  endtask

  task automatic model_write(input logic [28:0] addr, input logic [127:0] data, input logic [15:0] mask);
    logic [127:0] m;
    m = model.exists(idx_of(addr)) ? model[idx_of(addr)] : 'x;
    for (int b = 0; b < 16; b++) if (mask[b]) m[b*8 +: 8] = data[b*8 +: 8];
    model[idx_of(addr)] = m;
  endtask

  task automatic do_write(input logic [28:0] addr, input logic [127:0] data, input logic [15:0] mask);
    int a;
    issue_cmd(WR, addr, a);
    issue_wdf(data, mask, a);
    model_write(addr, data, mask);
  endtask

  task automatic do_read(input logic [28:0] addr, input bit check_lat);
    int a;
    issue_cmd(RD, addr, a);
    exp_data.push_back(model[idx_of(addr)]);
    exp_due.push_back(check_lat ? a + 1 + L : -1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_data.size() != 0; i++) tick();
    vectors++;
    if (exp_data.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout pending=%0d expected 0", exp_data.size());
      exp_data.delete(); exp_due.delete();
    end
    tick();
  endtask

  task automatic align(input int phase);
    bit ok = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      if (cyc >= 16 && ((cyc - 16) % 64) == phase) ok = 1;
      else tick();
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL align_timeout cyc=%0d expected phase %0d", cyc, phase);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, init_calib_complete,
         cmd_error, app_rd_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs rdy=%b wdf_rdy=%b vld=%b calib=%b err=%b expected all 0",
               app_rdy, app_wdf_rdy, app_rd_data_valid, init_calib_complete, cmd_error);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      vectors++;
      if ({app_rdy, app_wdf_rdy, init_calib_complete} !== 3'b000) begin
        miscompares++;
        $display("FAIL calib_wait cyc=%0d rdy=%b wdf_rdy=%b calib=%b expected 000",
                 cyc, app_rdy, app_wdf_rdy, init_calib_complete);
      end
      tick();
    end
    @(negedge clk);
    vectors++;
    if ({app_rdy, app_wdf_rdy, init_calib_complete} !== 3'b111 || cyc != 16) begin
      miscompares++;
      $display("FAIL calib_done cyc=%0d rdy=%b wdf_rdy=%b calib=%b expected 111 at 16",
               cyc, app_rdy, app_wdf_rdy, init_calib_complete);
    end
    tick();
  endtask

  task automatic test_write_read();
    do_write(29'h40, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 16'hFFFF);
    do_read(29'h40, 1'b1);
    wait_drain();
  endtask

  task automatic test_mask_alias();
    int a;
    do_write(29'h80, {128{1'b1}}, 16'hFFFF);
    do_write(29'h80, '0, 16'h000F);
    issue_cmd(RD, 29'h80, a);
    exp_data.push_back(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000);
    exp_due.push_back(-1);
    // bit 13 aliases onto idx 8; low bits [2:0] are ignored
    do_write(29'h2040, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 16'hFFFF);
    do_read(29'h47, 1'b0);
    wait_drain();
  endtask

  task automatic test_raw_order();
    int t, t1, d;
    align(8);
    issue_cmd(WR, 29'h100, t);
    issue_cmd(RD, 29'h100, t1);
    vectors++;
    if (t1 != t + 1) begin
      miscompares++;
      $display("FAIL raw_read_accept got_cyc=%0d expected_cyc=%0d", t1, t + 1);
    end
    for (int i = 0; i < 20 && cyc < t + 6; i++) tick();
    issue_wdf(128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D, 16'hFFFF, d);
    vectors++;
    if (d != t + 6) begin
      miscompares++;
      $display("FAIL raw_data_accept got_cyc=%0d expected_cyc=%0d", d, t + 6);
    end
    model_write(29'h100, 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D, 16'hFFFF);
    exp_data.push_back(model[idx_of(29'h100)]);
    exp_due.push_back(d + 2 + L);
    wait_drain();
  endtask

  task automatic test_refresh_stream();
    logic [28:0] addrs [3];
    addrs[0] = 29'h40; addrs[1] = 29'h80; addrs[2] = 29'h100;
    app_en = 1'b1; app_cmd = RD;
    for (int n = 0; n < 140; n++) begin
      app_addr = addrs[n % 3];
      @(negedge clk);
      vectors++;
      if (app_rdy !== !in_refresh(cyc)) begin
        miscompares++;
        $display("FAIL refresh_rdy cyc=%0d got=%b expected=%b", cyc, app_rdy, !in_refresh(cyc));
      end
      if (app_rdy) begin
        exp_data.push_back(model[idx_of(app_addr)]);
        exp_due.push_back(-1);
      end
      tick();
    end
    app_en = 1'b0;
    wait_drain();
  endtask

  task automatic test_fifo_full();
    logic [28:0] ra [4];
    int a, n;
    ra[0] = 29'h200; ra[1] = 29'h80; ra[2] = 29'h100; ra[3] = 29'h200;
    align(8);
    issue_cmd(WR, 29'h200, a);
    model_write(29'h200, 128'h0F0F_1234_5678_9ABC_DEF0_0BAD_F00D_7777, 16'hFFFF);
    n = 0;
    app_en = 1'b1; app_cmd = RD;
    for (int i = 0; i < 20 && n < 3; i++) begin
      app_addr = ra[n];
      @(negedge clk);
      if (app_rdy) begin
        exp_data.push_back(model[idx_of(ra[n])]); exp_due.push_back(-1); n++;
      end
      tick();
    end
    app_addr = ra[3];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (app_rdy !== 1'b0) begin
        miscompares++;
        $display("FAIL fifo_full_rdy cyc=%0d got=%b expected=0", cyc, app_rdy);
      end
      tick();
    end
    issue_wdf(128'h0F0F_1234_5678_9ABC_DEF0_0BAD_F00D_7777, 16'hFFFF, a);
    for (int i = 0; i < 20 && n < 4; i++) begin
      @(negedge clk);
      if (app_rdy) begin
        exp_data.push_back(model[idx_of(ra[3])]); exp_due.push_back(-1); n++;
      end
      tick();
    end
    app_en = 1'b0;
    vectors++;
    if (n != 4) begin
      miscompares++;
      $display("FAIL fifo_full_accepts got=%0d expected=4", n);
    end
    wait_drain();
  endtask

  task automatic test_illegal_and_reset();
    int a, nv;
    @(negedge clk);
    vectors++;
    if (cmd_error !== 1'b0) begin
      miscompares++;
      $display("FAIL cmd_error_pre got=%b expected=0", cmd_error);
    end
    tick();
    issue_cmd(3'b010, 29'h40, a);
    @(negedge clk);
    vectors++;
    if (cmd_error !== 1'b1 || cyc != a + 1) begin
      miscompares++;
      $display("FAIL cmd_error_set got=%b cyc=%0d expected=1 cyc=%0d", cmd_error, cyc, a + 1);
    end
    tick();
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (app_rd_data_valid) nv++;
      tick();
    end
    vectors++;
    if (nv != 0 || cmd_error !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_no_data got_valids=%0d err=%b expected 0 valids err=1", nv, cmd_error);
    end
    do_read(29'h80, 1'b0);
    wait_drain();
    // burst of reads, then reset while they are queued / in flight
    app_en = 1'b1; app_cmd = RD; app_addr = 29'h40;
    repeat (5) tick();
    rst_n = 1'b0; app_en = 1'b0;
    #1;
    vectors++;
    if ({app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, init_calib_complete,
         cmd_error, app_rd_data} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs rdy=%b wdf_rdy=%b vld=%b calib=%b err=%b expected all 0",
               app_rdy, app_wdf_rdy, app_rd_data_valid, init_calib_complete, cmd_error);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (app_rd_data_valid) nv++;
      tick();
    end
    vectors++;
    if (nv != 0 || cmd_error !== 1'b0 || init_calib_complete !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset got_valids=%0d err=%b calib=%b expected 0 0 1",
               nv, cmd_error, init_calib_complete);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_mask_alias();
    test_raw_order();
    test_refresh_stream();
    test_fifo_full();
    test_illegal_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog cyc=%0d expected bench to finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
